// File: rtl/dmem_responder_pkg.sv
// Shared data-memory bus definitions: FSM state codes and store byte-enable constants.
package dmem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] BE_WORD    = 4'hF;
  localparam logic [3:0] BE_HALF_LO = 4'h3;
  localparam logic [3:0] BE_HALF_HI = 4'hC;
  localparam logic [3:0] BE_B0      = 4'h1;
  localparam logic [3:0] BE_B1      = 4'h2;
  localparam logic [3:0] BE_B2      = 4'h4;
  localparam logic [3:0] BE_B3      = 4'h8;

endpackage

// File: rtl/dmem_array.sv
// Synchronous-write, asynchronous-read 32-bit RAM with per-byte write enables.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core: one outstanding request, programmable wait states,
// byte-enabled stores and range/alignment error reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [AW-3:0] word_addr;
  logic          addr_err;
  logic          access;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  assign word_addr = addr_q[AW-1:2];
  // DEPTH_WORDS is a power of two, so any set bit above the index field is out of range.
  assign addr_err  = (addr_q[1:0] != 2'b00) || ((word_addr >> IW) != '0);
  assign access    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_we    = access && we_q && !addr_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (be_q),
    .idx  (word_addr[IW-1:0]),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = WaitInit;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          err_d   = addr_err;
          rdata_d = (!we_q && !addr_err) ? mem_rdata : 32'd0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
